peripheral_apb_master: RTL

APB4 initiator that turns a simple valid/ready command stream into single APB transfers, and returns each result on a valid/ready response stream. It sits between a CPU-side or debug-side command source and APB-Lite peripherals such as the GPIO block. It is the requester end of the same bus those peripherals respond on. It adds a programmable access timeout so that a hung slave cannot stall the command source.

---
 rtl/peripheral_apb_master.sv | 101 ++++++++++
 1 files changed

// File: rtl/peripheral_apb_master.sv
// peripheral_apb_master: APB4 initiator turning a valid/ready command stream into single APB transfers with an access timeout
//   PCLK, PRESETn             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake; cmd_addr/cmd_write/cmd_wdata/cmd_strb carry the transfer
//   rsp_valid/rsp_ready       response handshake; rsp_rdata/rsp_err/rsp_timeout carry the result
//   busy                      a transfer is in progress (not IDLE)
//   PSEL..PWDATA, PRDATA,
//   PREADY, PSLVERR           APB4 requester interface
module peripheral_apb_master #(
    parameter int PDATA_SIZE = 8,
    parameter int PADDR_SIZE = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                    PRESETn,
    input  logic                    PCLK,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [PADDR_SIZE-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [PDATA_SIZE-1:0]   cmd_wdata,
    input  logic [PDATA_SIZE/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic                    PWRITE,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          limit;
    // cnt holds the number of wait cycles already spent, so the current ACCESS cycle is cnt+1
    assign limit = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    assign busy  = state != IDLE;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PSTRB       <= '0;
            PWDATA      <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    PADDR     <= cmd_addr;
                    PWRITE    <= cmd_write;
                    PWDATA    <= cmd_wdata;
                    PSTRB     <= cmd_write ? cmd_strb : '0;
                    PSEL      <= 1'b1;
                    cmd_ready <= 1'b0;
                    state     <= SETUP;
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY has priority over the timeout in the limit cycle
                    if (PREADY || limit) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PREADY && !PWRITE ? PRDATA : '0;
                        rsp_err     <= PREADY ? PSLVERR : 1'b1;
                        rsp_timeout <= !PREADY;
                        state       <= RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid   <= 1'b0;
                    rsp_err     <= 1'b0;
                    rsp_timeout <= 1'b0;
                    cmd_ready   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
